// File: rtl/key_cmd_sched.sv
// Key-blip command scheduler: arbitrates key blips into a 4-entry FIFO and
// issues one command per GAP_FRAMES video frames. Optional macro: KEY_CMD_COALESCE_EN.
module key_cmd_sched #(
  parameter int unsigned GAP_FRAMES = 1
) (
  input  logic       clk_i,
  input  logic       dreset_i,
  input  logic       key_up_i,
  input  logic       key_down_i,
  input  logic       key_left_i,
  input  logic       key_right_i,
  input  logic       key_enter_i,
  input  logic       key_game_reset_i,
  input  logic       frame_tick_i,
  input  logic       cmd_ready_i,
  output logic       cmd_valid_o,
  output logic [2:0] cmd_code_o,
  output logic       game_reset_out_o,
  output logic [2:0] fifo_count_o,
  output logic       overflow_o,
  output logic       dropped_o
);

  // state     | meaning
  // IDLE      | nothing pending, waiting for the FIFO to fill
  // WAIT_TICK | entry pending, waiting for the next frame_tick
  // ISSUE     | head offered on cmd_valid/cmd_code until accepted
  // HOLDOFF   | counting frame_ticks before the next command may issue
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TICK = 2'd1,
    ISSUE     = 2'd2,
    HOLDOFF   = 2'd3
  } state_t;

  localparam logic [3:0] GAP_LOAD = 4'(GAP_FRAMES);

  state_t     state_q, state_d;
  logic [3:0] gap_q, gap_d;
  logic [2:0] mem_q [4];
  logic [1:0] rd_ptr_q, wr_ptr_q;
  logic [2:0] count_q, count_d;
  logic       overflow_q, dropped_q, game_reset_q;

  logic [2:0] win_code;
  logic       lose;
  logic       game_reset;
  logic       handshake;
  logic       pop;
  logic       push_req;
  logic       push_ok;
  logic       overflow_set;
  logic       coalesce_hit;

  assign game_reset = key_game_reset_i;

  // Fixed priority: enter > up > down > left > right; any other blip is lost.
  always_comb begin
    win_code = 3'd0;
    lose     = 1'b0;
    if (key_enter_i) begin
      win_code = 3'd5;
      lose     = key_up_i | key_down_i | key_left_i | key_right_i;
    end else if (key_up_i) begin
      win_code = 3'd1;
      lose     = key_down_i | key_left_i | key_right_i;
    end else if (key_down_i) begin
      win_code = 3'd2;
      lose     = key_left_i | key_right_i;
    end else if (key_left_i) begin
      win_code = 3'd3;
      lose     = key_right_i;
    end else if (key_right_i) begin
      win_code = 3'd4;
    end
  end

`ifdef KEY_CMD_COALESCE_EN
  logic [2:0] newest;
  assign newest       = mem_q[wr_ptr_q - 2'd1];
  assign coalesce_hit = (count_q != 3'd0) && (newest == win_code);
`else
  assign coalesce_hit = 1'b0;
`endif

  assign handshake    = (state_q == ISSUE) && cmd_ready_i;
  assign pop          = handshake && !game_reset;
  assign push_req     = !game_reset && (win_code != 3'd0) && !coalesce_hit;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok      = push_req && ((count_q != 3'd4) || pop);
  assign overflow_set = push_req && (count_q == 3'd4) && !pop;
  assign count_d      = count_q + {2'b00, push_ok} - {2'b00, pop};

  always_ff @(posedge clk_i or negedge dreset_i) begin
    if (!dreset_i) begin
      for (int i = 0; i < 4; i++) mem_q[i] <= 3'd0;
      rd_ptr_q   <= 2'd0;
      wr_ptr_q   <= 2'd0;
      count_q    <= 3'd0;
      overflow_q <= 1'b0;
      dropped_q  <= 1'b0;
    end else if (game_reset) begin
      rd_ptr_q   <= 2'd0;
      wr_ptr_q   <= 2'd0;
      count_q    <= 3'd0;
      overflow_q <= 1'b0;
      dropped_q  <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= win_code;
        wr_ptr_q        <= wr_ptr_q + 2'd1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
      count_q    <= count_d;
      overflow_q <= overflow_q | overflow_set;
      dropped_q  <= dropped_q | lose;
    end
  end

  always_ff @(posedge clk_i or negedge dreset_i) begin
    if (!dreset_i) begin
      state_q      <= IDLE;
      gap_q        <= 4'd0;
      game_reset_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      gap_q        <= gap_d;
      game_reset_q <= game_reset;
    end
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    if (game_reset) begin
      state_d = IDLE;
      gap_d   = 4'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (count_q != 3'd0) state_d = WAIT_TICK;
        end
        WAIT_TICK: begin
          if (frame_tick_i) state_d = ISSUE;
        end
        ISSUE: begin
          if (cmd_ready_i) begin
            state_d = HOLDOFF;
            gap_d   = GAP_LOAD;
          end
        end
        HOLDOFF: begin
          if (frame_tick_i) begin
            if (gap_q > 4'd1) begin
              gap_d = gap_q - 4'd1;
            end else begin
              state_d = (count_q != 3'd0) ? ISSUE : IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Head cannot move while offered: pops happen only on the handshake itself.
  assign cmd_valid_o      = (state_q == ISSUE);
  assign cmd_code_o       = (state_q == ISSUE) ? mem_q[rd_ptr_q] : 3'd0;
  assign game_reset_out_o = game_reset_q;
  assign fifo_count_o     = count_q;
  assign overflow_o       = overflow_q;
  assign dropped_o        = dropped_q;

endmodule

// File: tb/tb_key_cmd_sched.sv
// Bench for key_cmd_sched: two instances (GAP_FRAMES 1 and 3) driven in lockstep
// and compared every cycle against a queue-level scheduling model.
module tb_key_cmd_sched;

  logic       clk = 1'b0;
  logic       dreset;
  logic       k_up, k_down, k_left, k_right, k_enter, k_grst, tick;
  logic       rdy [2];
  logic       cv  [2];
  logic [2:0] cc  [2];
  logic [2:0] fc  [2];
  logic       ov  [2];
  logic       dr  [2];
  logic       gro [2];

  always #5 clk = ~clk;

  key_cmd_sched #(.GAP_FRAMES(1)) u_gap1 (
    .clk_i(clk), .dreset_i(dreset),
    .key_up_i(k_up), .key_down_i(k_down), .key_left_i(k_left),
    .key_right_i(k_right), .key_enter_i(k_enter), .key_game_reset_i(k_grst),
    .frame_tick_i(tick), .cmd_ready_i(rdy[0]),
    .cmd_valid_o(cv[0]), .cmd_code_o(cc[0]), .game_reset_out_o(gro[0]),
    .fifo_count_o(fc[0]), .overflow_o(ov[0]), .dropped_o(dr[0])
  );

  key_cmd_sched #(.GAP_FRAMES(3)) u_gap3 (
    .clk_i(clk), .dreset_i(dreset),
    .key_up_i(k_up), .key_down_i(k_down), .key_left_i(k_left),
    .key_right_i(k_right), .key_enter_i(k_enter), .key_game_reset_i(k_grst),
    .frame_tick_i(tick), .cmd_ready_i(rdy[1]),
    .cmd_valid_o(cv[1]), .cmd_code_o(cc[1]), .game_reset_out_o(gro[1]),
    .fifo_count_o(fc[1]), .overflow_o(ov[1]), .dropped_o(dr[1])
  );

  localparam logic [6:0] G = 7'b1000000;
  localparam logic [6:0] E = 7'b0100000;
  localparam logic [6:0] U = 7'b0010000;
  localparam logic [6:0] D = 7'b0001000;
  localparam logic [6:0] L = 7'b0000100;
  localparam logic [6:0] R = 7'b0000010;
  localparam logic [6:0] T = 7'b0000001;

`ifdef KEY_CMD_COALESCE_EN
  localparam int EXP_DOUBLE_DOWN = 1;
`else
  localparam int EXP_DOUBLE_DOWN = 2;
`endif

  int errors = 0;
  int checks = 0;

  // Model: FIFO contents as a plain array, plus scheduling facts.
  int mq [2][4];
  int mcnt   [2];
  bit moffer [2];  // a command is currently on offer
  int mcool  [2];  // frame ticks still owed after the last accepted command
  bit marmed [2];  // pending entry has been seen; next tick issues it
  bit movf [2], mdrp [2], mgro [2];

  function automatic int gap_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_rst();
    for (int i = 0; i < 2; i++) begin
      mcnt[i] = 0; moffer[i] = 0; mcool[i] = 0; marmed[i] = 0;
      movf[i] = 0; mdrp[i] = 0; mgro[i] = 0;
    end
  endtask

  task automatic model_step();
    int sz, win, nk;
    bit hs, coal;
    for (int i = 0; i < 2; i++) begin
      hs = moffer[i] && rdy[i];
      sz = mcnt[i];
      mgro[i] = k_grst;
      if (k_grst) begin
        mcnt[i] = 0; movf[i] = 0; mdrp[i] = 0;
        moffer[i] = 0; mcool[i] = 0; marmed[i] = 0;
      end else begin
        nk = int'(k_enter) + int'(k_up) + int'(k_down) + int'(k_left) + int'(k_right);
        if (nk > 1) mdrp[i] = 1;
        win = k_enter ? 5 : k_up ? 1 : k_down ? 2 : k_left ? 3 : k_right ? 4 : 0;
        coal = 0;
`ifdef KEY_CMD_COALESCE_EN
        coal = (sz > 0) && (mq[i][sz-1] == win);
`endif
        if (hs) begin
          for (int j = 0; j < 3; j++) mq[i][j] = mq[i][j+1];
          mcnt[i]--;
        end
        if (win != 0 && !coal) begin
          if (sz == 4 && !hs) movf[i] = 1;
          else begin
            mq[i][mcnt[i]] = win;
            mcnt[i]++;
          end
        end
        if (moffer[i]) begin
          if (hs) begin moffer[i] = 0; mcool[i] = gap_of(i); end
        end else if (mcool[i] > 0) begin
          if (tick) begin
            if (mcool[i] > 1) mcool[i]--;
            else begin mcool[i] = 0; moffer[i] = (sz > 0); end
          end
        end else if (marmed[i]) begin
          if (tick) begin marmed[i] = 0; moffer[i] = 1; end
        end else begin
          marmed[i] = (sz > 0);
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("valid%0d", i), 8'(cv[i]), 8'(moffer[i]));
      chk($sformatf("code%0d", i), 8'(cc[i]), 8'(moffer[i] ? mq[i][0] : 0));
      chk($sformatf("count%0d", i), 8'(fc[i]), 8'(mcnt[i]));
      chk($sformatf("overflow%0d", i), 8'(ov[i]), 8'(movf[i]));
      chk($sformatf("dropped%0d", i), 8'(dr[i]), 8'(mdrp[i]));
      chk($sformatf("grst_out%0d", i), 8'(gro[i]), 8'(mgro[i]));
    end
  endtask

  task automatic cyc(input logic [6:0] v);
    {k_grst, k_enter, k_up, k_down, k_left, k_right, tick} = v;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(7'd0);
  endtask

  task automatic set_rdy(input bit r0, input bit r1);
    rdy[0] = r0;
    rdy[1] = r1;
  endtask

  initial begin
    dreset = 1'b1;
    {k_grst, k_enter, k_up, k_down, k_left, k_right, tick} = 7'd0;
    set_rdy(0, 0);
    model_rst();
    #1 dreset = 1'b0;
    #2 check_all();
    #9 dreset = 1'b1;

    // Single command, ready held high.
    set_rdy(1, 1);
    cyc(U); idle(1); cyc(T);
    chk("single_valid", 8'(cv[0]), 8'd1);
    chk("single_code", 8'(cc[0]), 8'd1);
    idle(3);

    // Five blips with no tick: fourth fills, fifth overflows; then drain.
    set_rdy(0, 0);
    cyc(G); cyc(U); cyc(D); cyc(L); cyc(R); cyc(E);
    chk("five_count", 8'(fc[0]), 8'd4);
    chk("five_overflow", 8'(ov[0]), 8'd1);
    set_rdy(1, 1);
    for (int n = 0; n < 14; n++) begin cyc(T); idle(3); end

    // Same-cycle left and right.
    cyc(G); cyc(L | R);
    chk("lr_count", 8'(fc[0]), 8'd1);
    chk("lr_dropped", 8'(dr[0]), 8'd1);
    idle(8);

    // Gap of three frames: issues on ticks 1, 4, 7 only.
    cyc(G); cyc(U); cyc(D); cyc(L); idle(2);
    for (int n = 1; n <= 8; n++) begin
      cyc(T);
      chk($sformatf("gap3_tick%0d", n), 8'(cv[1]), 8'((n == 1 || n == 4 || n == 7) ? 1 : 0));
      idle(3);
    end

    // Game reset while a command is held on offer.
    set_rdy(0, 0);
    cyc(G); cyc(U); cyc(D); idle(1); cyc(T); idle(1);
    cyc(G | U);
    chk("grst_valid", 8'(cv[0]), 8'd0);
    chk("grst_count", 8'(fc[0]), 8'd0);
    chk("grst_pulse", 8'(gro[0]), 8'd1);
    idle(1);
    chk("grst_pulse_end", 8'(gro[0]), 8'd0);

    // Game reset coinciding with a handshake.
    cyc(U); cyc(D); idle(1); cyc(T);
    set_rdy(1, 1);
    cyc(G);
    chk("grst_hs_count", 8'(fc[0]), 8'd0);
    idle(2);

    // Repeated identical blip.
    cyc(G); cyc(D); cyc(D);
    chk("double_down", 8'(fc[0]), 8'(EXP_DOUBLE_DOWN));
    chk("double_down_ovf", 8'(ov[0]), 8'd0);
    idle(2);

    // Asynchronous reset while a command is on offer.
    set_rdy(0, 0);
    cyc(G); cyc(E); idle(1); cyc(T); idle(1);
    #2 dreset = 1'b0;
    model_rst();
    #1 check_all();
    dreset = 1'b1;
    cyc(D); cyc(T); idle(1); cyc(T);
    set_rdy(1, 1);
    idle(4);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      set_rdy(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      cyc({($urandom_range(0, 49) == 0),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 4) == 0)});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_cmd_sched.md
KEY_CMD_SCHED -- requirements
Module: key_cmd_sched

Interface
REQ-001 Parameter: GAP_FRAMES, default 1, minimum frame_tick count between issued commands (legal 1..15).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 dreset  input  1  asynchronous active-low reset.
REQ-004 key_up, key_down, key_left, key_right, key_enter  input  1 each  one-cycle key blips.
REQ-005 key_game_reset  input  1  one-cycle game-reset blip.
REQ-006 frame_tick  input  1  one-cycle pulse at start of each video frame.
REQ-007 cmd_valid  output  1  command offered to game engine.
REQ-008 cmd_code  output  3  1=UP, 2=DOWN, 3=LEFT, 4=RIGHT, 5=ENTER; 0 when cmd_valid low.
REQ-009 cmd_ready  input  1  game engine accepts command; handshake = cmd_valid & cmd_ready.
REQ-010 game_reset_out  output  1  registered one-cycle pulse, one cycle after key_game_reset.
REQ-011 fifo_count  output  3  entries held (0..4).
REQ-012 overflow  output  1  sticky: push lost to full FIFO.
REQ-013 dropped  output  1  sticky: key blip lost to same-cycle arbitration.

Function
REQ-014 Arbitration SHALL use priority game_reset > enter > up > down > left > right; only the winner acts per cycle; any losing blip sets dropped.
REQ-015 Winning key blip (non-reset) SHALL push its code into a 4-entry FIFO; push visible in fifo_count next cycle.
REQ-016 Push when full without same-cycle pop SHALL be discarded and set overflow; push when full with same-cycle pop SHALL be accepted (count stays 4).
REQ-017 FIFO SHALL have no bypass: push into empty FIFO becomes issuable no earlier than the next frame_tick.
REQ-018 FSM states: IDLE, WAIT_TICK, ISSUE, HOLDOFF.
REQ-019 IDLE: fifo_count != 0 -> WAIT_TICK next cycle.
REQ-020 WAIT_TICK: frame_tick -> ISSUE; cmd_valid=1, cmd_code=FIFO head, from next cycle.
REQ-021 ISSUE: cmd_valid and cmd_code SHALL stay stable until handshake; frame_tick ignored; handshake pops head, loads gap_cnt=GAP_FRAMES, -> HOLDOFF, cmd_valid=0 next cycle.
REQ-022 HOLDOFF: each frame_tick with gap_cnt>1 decrements gap_cnt; frame_tick with gap_cnt==1 -> ISSUE if FIFO non-empty, else IDLE.
REQ-023 Result: at most one command per GAP_FRAMES frames; GAP_FRAMES=1 allows one per frame.
REQ-024 key_game_reset SHALL in one cycle flush FIFO (count 0), clear overflow and dropped, drop cmd_valid, force IDLE, and pulse game_reset_out; same-cycle key blips ignored.
REQ-025 Simultaneous handshake and key_game_reset: game reset wins; popped entry discarded with flush.

Reset
REQ-026 dreset low SHALL asynchronously force: IDLE, fifo_count=0, gap_cnt=0, cmd_valid=0, cmd_code=0, game_reset_out=0, overflow=0, dropped=0.
REQ-027 dreset asserted mid-ISSUE SHALL abandon the command without a handshake; first push after release follows REQ-017.

Configuration
REQ-028 Macro KEY_CMD_COALESCE_EN: when defined, a push whose code equals the newest FIFO entry (count>0, including an entry currently offered in ISSUE) SHALL be silently discarded, setting neither overflow nor dropped; when undefined, every winning blip is pushed per REQ-015/016.

Verification
REQ-029 GAP_FRAMES=1, key_up blip, frame_tick, cmd_ready held 1 -> cmd_valid=1, cmd_code=1 for exactly one cycle, fifo_count 1->0.
REQ-030 Five blips (up,down,left,right,enter) with no frame_tick -> fifo_count=4, overflow=1, issued order 1,2,3,4 across four frames.
REQ-031 key_left and key_right in same cycle -> only code 3 queued, dropped=1.
REQ-032 GAP_FRAMES=3, three queued entries, cmd_ready=1 -> commands issued on frame_ticks 1, 4, 7 only.
REQ-033 Two entries queued, cmd_valid high, cmd_ready=0, then key_game_reset -> next cycle cmd_valid=0, fifo_count=0, overflow=0, game_reset_out=1 for one cycle.
REQ-034 KEY_CMD_COALESCE_EN defined, key_down blip twice without frame_tick -> fifo_count=1, overflow=0, dropped=0; undefined -> fifo_count=2.
